text_console_render: RTL and testbench

- Parametrised UART-fed text console for the VGA path: a COLS x ROWS character buffer rendered inside a fixed pixel window, in 8x16 glyphs from an external ascii ROM.
- Successor to the fixed 32x4 text window. Adds a valid/ready write handshake, cursor tracking, CR/backspace/form-feed handling, line wrap and hardware scrolling through a circular row offset.
- All logic is synchronous to clk, including the pixel pipeline, which has a fixed latency.

---
 rtl/text_console_render.sv | 267 ++++++++++++++++++++++++++
 tb/tb_text_console_render.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_render.sv
// UART-fed COLS x ROWS text console rendered as 8x16 glyphs inside a fixed VGA window.
// Optional `CURSOR_BLINK_EN adds a blinking underline cursor on the logical cursor cell.
module text_console_render #(
  parameter int unsigned COLS   = 32,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned X0     = 192,
  parameter int unsigned Y0     = 208,
  parameter logic [11:0] BG_RGB = 12'hFFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_valid_i,
  input  logic [7:0]  wr_data_i,
  output logic        wr_ready_o,
  input  logic        video_on_i,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic [1:0]  color_sel_i,
  output logic [10:0] rom_addr_o,
  input  logic [7:0]  rom_data_i,
  output logic [11:0] rgb_o
);

  localparam int unsigned Cells = COLS * ROWS;
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned AW    = CW + RW;

  localparam logic [AW-1:0] LastCell = AW'(Cells - 1);
  localparam logic [AW-1:0] LastCol  = AW'(COLS - 1);
  localparam logic [CW-1:0] MaxCol   = CW'(COLS - 1);
  localparam logic [RW-1:0] MaxRow   = RW'(ROWS - 1);
  localparam logic [6:0]    Space    = 7'h20;
  localparam logic [6:0]    ChCr     = 7'h0D;
  localparam logic [6:0]    ChBs     = 7'h08;
  localparam logic [6:0]    ChFf     = 7'h0C;
  localparam logic [11:0]   XLo      = 12'(X0);
  localparam logic [11:0]   XHi      = 12'(X0 + COLS * 8);
  localparam logic [11:0]   YLo      = 12'(Y0);
  localparam logic [11:0]   YHi      = 12'(Y0 + ROWS * 16);

  typedef enum logic [1:0] {StClrAll, StIdle, StClrRow} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]   cur_col_q, cur_col_d;
  logic [RW-1:0]   cur_row_q, cur_row_d;
  logic [RW-1:0]   top_row_q, top_row_d;
  logic            newline;

  logic [6:0]      ch;
  logic            is_print;
  logic [RW-1:0]   cur_phys_row;
  logic [RW-1:0]   bot_phys_row;
  logic [CW-1:0]   bs_col;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [6:0]      mem_wdata;
  logic [6:0]      mem_q [Cells];

  assign ch           = wr_data_i[6:0];
  assign is_print     = (ch >= 7'h20) && (ch <= 7'h7E);
  assign cur_phys_row = top_row_q + cur_row_q;
  // After a scroll top_row_q already points past the row being recycled.
  assign bot_phys_row = top_row_q - 1'b1;
  assign bs_col       = cur_col_q - 1'b1;

  // ---------------------------------------------------------------- FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StClrAll;
      clr_cnt_q <= '0;
      cur_col_q <= '0;
      cur_row_q <= '0;
      top_row_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      top_row_q <= top_row_d;
    end
  end

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    top_row_d = top_row_q;
    newline   = 1'b0;
    unique case (state_q)
      StClrAll: begin
        if (clr_cnt_q == LastCell) state_d = StIdle;
        else                       clr_cnt_d = clr_cnt_q + 1'b1;
      end
      StClrRow: begin
        if (clr_cnt_q == LastCol) state_d = StIdle;
        else                      clr_cnt_d = clr_cnt_q + 1'b1;
      end
      StIdle: begin
        if (wr_valid_i) begin
          if (is_print) begin
            if (cur_col_q == MaxCol) begin
              cur_col_d = '0;
              newline   = 1'b1;
            end else begin
              cur_col_d = cur_col_q + 1'b1;
            end
          end else if (ch == ChCr) begin
            cur_col_d = '0;
            newline   = 1'b1;
          end else if (ch == ChBs) begin
            if (cur_col_q != '0) cur_col_d = bs_col;
          end else if (ch == ChFf) begin
            cur_col_d = '0;
            cur_row_d = '0;
            top_row_d = '0;
            clr_cnt_d = '0;
            state_d   = StClrAll;
          end
          if (newline) begin
            if (cur_row_q != MaxRow) begin
              cur_row_d = cur_row_q + 1'b1;
            end else begin
              top_row_d = top_row_q + 1'b1;
              clr_cnt_d = '0;
              state_d   = StClrRow;
            end
          end
        end
      end
      default: state_d = StClrAll;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  always_comb begin
    wr_ready_o = (state_q == StIdle);
    mem_we     = 1'b0;
    mem_waddr  = clr_cnt_q;
    mem_wdata  = Space;
    unique case (state_q)
      StClrAll: mem_we = 1'b1;
      StClrRow: begin
        mem_we    = 1'b1;
        mem_waddr = {bot_phys_row, clr_cnt_q[CW-1:0]};
      end
      StIdle: begin
        if (wr_valid_i && is_print) begin
          mem_we    = 1'b1;
          mem_waddr = {cur_phys_row, cur_col_q};
          mem_wdata = ch;
        end else if (wr_valid_i && (ch == ChBs) && (cur_col_q != '0)) begin
          mem_we    = 1'b1;
          mem_waddr = {cur_phys_row, bs_col};
        end
      end
      default: mem_we = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- character buffer
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------- pixel pipeline
  logic [9:0]    dx, dy;
  logic [CW-1:0] dcol;
  logic [RW-1:0] drow;
  logic [RW-1:0] rd_row;
  logic [AW-1:0] rd_addr;
  logic          in_win;

  logic [6:0]    char_q;
  logic [3:0]    glyph_row_q;
  logic [2:0]    bit_q, bit_q2;
  logic          in_win_q, in_win_q2;
  logic          von_q, von_q2;
  logic          pix_on, glyph_on;
  logic [11:0]   fg_rgb;
  logic [11:0]   rgb_q, rgb_d;
  logic          unused_bits;

  assign dx      = x_i - 10'(X0);
  assign dy      = y_i - 10'(Y0);
  assign dcol    = dx[CW+2:3];
  assign drow    = dy[RW+3:4];
  assign rd_row  = drow + top_row_q;
  assign rd_addr = {rd_row, dcol};
  assign in_win  = ({2'b00, x_i} >= XLo) && ({2'b00, x_i} < XHi) &&
                   ({2'b00, y_i} >= YLo) && ({2'b00, y_i} < YHi);
  assign unused_bits = ^{wr_data_i[7], dx, dy};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      char_q      <= '0;
      glyph_row_q <= '0;
      bit_q       <= '0;
      in_win_q    <= 1'b0;
      von_q       <= 1'b0;
      bit_q2      <= '0;
      in_win_q2   <= 1'b0;
      von_q2      <= 1'b0;
      rgb_q       <= '0;
    end else begin
      char_q      <= mem_q[rd_addr];
      glyph_row_q <= dy[3:0];
      bit_q       <= dx[2:0];
      in_win_q    <= in_win;
      von_q       <= video_on_i;
      bit_q2      <= bit_q;
      in_win_q2   <= in_win_q;
      von_q2      <= von_q;
      rgb_q       <= rgb_d;
    end
  end

  assign rom_addr_o = {char_q, glyph_row_q};
  // Bit 7 of the ROM row is the leftmost pixel, so index with the inverted column.
  assign pix_on     = rom_data_i[~bit_q2];

`ifdef CURSOR_BLINK_EN
  logic [23:0] blink_cnt_q;
  logic        cur_hit_q, cur_hit_q2;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      blink_cnt_q <= '0;
      cur_hit_q   <= 1'b0;
      cur_hit_q2  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
      cur_hit_q   <= (drow == cur_row_q) && (dcol == cur_col_q) && (dy[3:1] == 3'b111);
      cur_hit_q2  <= cur_hit_q;
    end
  end

  assign glyph_on = pix_on | (cur_hit_q2 & blink_cnt_q[23]);
`else
  assign glyph_on = pix_on;
`endif

  always_comb begin
    fg_rgb = 12'h00F;
    unique case (color_sel_i)
      2'b00: fg_rgb = 12'h00F;
      2'b01: fg_rgb = 12'hF00;
      2'b10: fg_rgb = 12'h0F0;
      2'b11: fg_rgb = 12'hFF0;
      default: fg_rgb = 12'h00F;
    endcase
  end

  always_comb begin
    rgb_d = BG_RGB;
    if (!von_q2)        rgb_d = 12'h000;
    else if (!in_win_q2) rgb_d = 12'hFFF;
    else if (glyph_on)  rgb_d = fg_rgb;
  end

  assign rgb_o = rgb_q;

endmodule

// File: tb/tb_text_console_render.sv
// Directed self-checking bench for text_console_render with a simple glyph ROM model.
module tb_text_console_render;

  localparam int X0 = 192;
  localparam int Y0 = 208;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        video_on;
  logic [9:0]  x, y;
  logic [1:0]  color_sel;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [11:0] rgb;

  int n_assert = 0;
  int n_fail   = 0;

  text_console_render dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_valid_i  (wr_valid),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .video_on_i  (video_on),
    .x_i         (x),
    .y_i         (y),
    .color_sel_i (color_sel),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .rgb_o       (rgb)
  );

  always #5 clk = ~clk;

  // Space is blank; every other glyph row lights its leftmost and rightmost pixel.
  always @(posedge clk) rom_data <= (rom_addr[10:4] == 7'h20) ? 8'h00 : 8'h81;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (!wr_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      n_assert++;
      n_fail++;
      $display("FAIL send_timeout: byte %h, wr_ready still %b", b, wr_ready);
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_cell(input int row, input int col, output logic [6:0] c);
    x = 10'(X0 + col * 8);
    y = 10'(Y0 + row * 16);
    tick();
    c = rom_addr[10:4];
  endtask

  task automatic set_pixel(input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int n, bad;
    logic [6:0] c;
    reset = 1'b1;
    repeat (3) tick();
    n_assert++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", wr_ready); end
    n_assert++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    n_assert++;
    if (rom_addr !== 11'h000) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
    reset = 1'b0;
    n = 0;
    while (!wr_ready && n < 1000) begin
      tick();
      n++;
    end
    n_assert++;
    if (n != 128) begin n_fail++; $display("FAIL clear_len: got %0d cycles want 128", n); end
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 32; k++) begin
        read_cell(r, k, c);
        if (c !== 7'h20) bad++;
      end
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL clear_cells: got %0d non-space cells want 0", bad); end
    set_pixel(X0 + 3, Y0 + 5);
    n_assert++;
    if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL clear_rgb: got %h want FFF", rgb); end
  endtask

  task automatic test_text();
    logic [6:0] c;
    logic [6:0] exp_c [5];
    int rr [5];
    int cc [5];
    exp_c = '{7'h41, 7'h42, 7'h43, 7'h44, 7'h20};
    rr    = '{0, 0, 1, 1, 1};
    cc    = '{0, 1, 0, 1, 2};
    send(8'h41);
    send(8'hC2);  // bit 7 must be ignored
    send(8'h0D);
    send(8'h43);
    send(8'h44);  // lands on the cursor left behind by "C"
    for (int i = 0; i < 5; i++) begin
      read_cell(rr[i], cc[i], c);
      n_assert++;
      if (c !== exp_c[i]) begin
        n_fail++;
        $display("FAIL text_cell(%0d,%0d): got %h want %h", rr[i], cc[i], c, exp_c[i]);
      end
    end
    color_sel = 2'b00;
    set_pixel(0, 0);
    x = 10'(X0);
    y = 10'(Y0);
    tick();
    n_assert++;
    if (rom_addr !== {7'h41, 4'h0}) begin
      n_fail++; $display("FAIL lat_rom_addr: got %h want %h", rom_addr, {7'h41, 4'h0});
    end
    tick();
    n_assert++;
    if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL lat_rgb_early: got %h want FFF", rgb); end
    tick();
    n_assert++;
    if (rgb !== 12'h00F) begin n_fail++; $display("FAIL lat_rgb: got %h want 00F", rgb); end
    for (int r = 1; r < 16; r++) begin
      y = 10'(Y0 + r);
      tick();
      n_assert++;
      if (rom_addr !== {7'h41, 4'(r)}) begin
        n_fail++; $display("FAIL scan_rom_addr r=%0d: got %h want %h", r, rom_addr, {7'h41, 4'(r)});
      end
      tick();
      tick();
      n_assert++;
      if (rgb !== 12'h00F) begin n_fail++; $display("FAIL scan_rgb r=%0d: got %h want 00F", r, rgb); end
    end
  endtask

  task automatic test_scroll();
    int n, bad_mid, bad_bot;
    logic [6:0] c;
    send(8'h0C);
    send(8'h50);
    send(8'h0D);
    send(8'h51);
    send(8'h0D);
    send(8'h0D);
    wr_data  = 8'h0D;
    wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 2000) begin tick(); n++; end
    tick();
    wr_valid = 1'b0;
    n = 0;
    while (!wr_ready && n < 1000) begin tick(); n++; end
    n_assert++;
    if (n != 32) begin n_fail++; $display("FAIL scroll_len: got %0d cycles want 32", n); end
    read_cell(0, 0, c);
    n_assert++;
    if (c !== 7'h51) begin n_fail++; $display("FAIL scroll_row0: got %h want 51", c); end
    bad_mid = 0;
    bad_bot = 0;
    for (int r = 1; r < 4; r++)
      for (int k = 0; k < 32; k++) begin
        read_cell(r, k, c);
        if (c !== 7'h20) begin
          if (r == 3) bad_bot++;
          else        bad_mid++;
        end
      end
    n_assert++;
    if (bad_mid != 0) begin n_fail++; $display("FAIL scroll_mid: got %0d non-space want 0", bad_mid); end
    n_assert++;
    if (bad_bot != 0) begin n_fail++; $display("FAIL scroll_bottom: got %0d non-space want 0", bad_bot); end
  endtask

  task automatic test_wrap();
    logic [6:0] c;
    send(8'h0C);
    for (int i = 0; i < 33; i++) send(8'(8'h21 + i));
    read_cell(0, 0, c);
    n_assert++;
    if (c !== 7'h21) begin n_fail++; $display("FAIL wrap_first: got %h want 21", c); end
    read_cell(0, 31, c);
    n_assert++;
    if (c !== 7'h40) begin n_fail++; $display("FAIL wrap_last_col: got %h want 40", c); end
    read_cell(1, 0, c);
    n_assert++;
    if (c !== 7'h41) begin n_fail++; $display("FAIL wrap_next_row: got %h want 41", c); end
    send(8'h08);
    read_cell(1, 0, c);
    n_assert++;
    if (c !== 7'h20) begin n_fail++; $display("FAIL bs_erase: got %h want 20", c); end
    send(8'h08);
    read_cell(0, 31, c);
    n_assert++;
    if (c !== 7'h40) begin n_fail++; $display("FAIL bs_noop: got %h want 40", c); end
    send(8'h5A);
    read_cell(1, 0, c);
    n_assert++;
    if (c !== 7'h5A) begin n_fail++; $display("FAIL bs_cursor: got %h want 5A", c); end
    read_cell(1, 1, c);
    n_assert++;
    if (c !== 7'h20) begin n_fail++; $display("FAIL bs_cursor_next: got %h want 20", c); end
  endtask

  task automatic test_color();
    logic [11:0] exp_fg [4];
    exp_fg = '{12'h00F, 12'hF00, 12'h0F0, 12'hFF0};
    for (int s = 0; s < 4; s++) begin
      color_sel = 2'(s);
      set_pixel(X0, Y0 + 2);
      n_assert++;
      if (rgb !== exp_fg[s]) begin n_fail++; $display("FAIL color_%0d: got %h want %h", s, rgb, exp_fg[s]); end
    end
    color_sel = 2'b01;
    set_pixel(X0 + 1, Y0 + 2);
    n_assert++;
    if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL unlit_bg: got %h want FFF", rgb); end
    set_pixel(X0 + 255, Y0);
    n_assert++;
    if (rgb !== 12'hF00) begin n_fail++; $display("FAIL right_edge: got %h want F00", rgb); end
    set_pixel(X0 + 256, Y0);
    n_assert++;
    if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL right_out: got %h want FFF", rgb); end
    set_pixel(X0 - 1, Y0);
    n_assert++;
    if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL left_out: got %h want FFF", rgb); end
    set_pixel(X0, Y0);
    video_on = 1'b0;
    tick();
    tick();
    n_assert++;
    if (rgb !== 12'hF00) begin n_fail++; $display("FAIL blank_early: got %h want F00", rgb); end
    tick();
    n_assert++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL blank: got %h want 000", rgb); end
    video_on = 1'b1;
  endtask

  task automatic test_reset_midclear();
    int n, bad;
    logic [6:0] c;
    wr_data  = 8'h0C;
    wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 2000) begin tick(); n++; end
    tick();
    wr_valid = 1'b0;
    repeat (20) tick();
    reset    = 1'b1;
    wr_data  = 8'h4D;
    wr_valid = 1'b1;
    tick();
    n_assert++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL midclr_ready: got %b want 0", wr_ready); end
    tick();
    reset = 1'b0;
    n = 0;
    while (!wr_ready && n < 1000) begin tick(); n++; end
    wr_valid = 1'b0;
    n_assert++;
    if (n != 128) begin n_fail++; $display("FAIL midclr_len: got %0d cycles want 128", n); end
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 32; k++) begin
        read_cell(r, k, c);
        if (c !== 7'h20) bad++;
      end
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL midclr_cells: got %0d non-space want 0", bad); end
    send(8'h4E);
    read_cell(0, 0, c);
    n_assert++;
    if (c !== 7'h4E) begin n_fail++; $display("FAIL midclr_home: got %h want 4E", c); end
    read_cell(0, 1, c);
    n_assert++;
    if (c !== 7'h20) begin n_fail++; $display("FAIL midclr_next: got %h want 20", c); end
  endtask

  initial begin
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    video_on  = 1'b1;
    x         = '0;
    y         = '0;
    color_sel = 2'b00;
    test_reset();
    test_text();
    test_scroll();
    test_wrap();
    test_color();
    test_reset_midclear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
